// File: rtl/bp_lce_resp_arbiter_n.sv
// N-source buffered arbiter for the LCE-to-CCE response channel.
// Each source has its own FIFO; grant is fixed-priority with starvation promotion or round-robin.
module bp_lce_resp_arbiter_n #(
  parameter  int num_src_p      = 2,
  parameter  int data_width_p   = 64,
  parameter  int fifo_els_p     = 2,
  parameter  int rr_mode_p      = 0,
  parameter  int starve_limit_p = 8,
  localparam int id_width_lp    = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_src_p*data_width_p-1:0] src_data_i,
  input  logic [num_src_p-1:0]              src_v_i,
  output logic [num_src_p-1:0]              src_ready_o,
  output logic [data_width_p-1:0]           resp_o,
  output logic                              resp_v_o,
  input  logic                              resp_ready_i,
  output logic [id_width_lp-1:0]            grant_id_o,
  output logic [num_src_p-1:0]              starved_o
);

  localparam int ptr_w_lp    = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w_lp    = $clog2(fifo_els_p + 1);
  localparam int starve_w_lp = $clog2(starve_limit_p + 1);

  logic [num_src_p-1:0]                   nonempty;
  logic [num_src_p-1:0]                   starved;
  logic [num_src_p-1:0]                   deq;
  logic [num_src_p-1:0][data_width_p-1:0] head_data;

  logic                   lock_reg;
  logic [id_width_lp-1:0] lock_id_reg;
  logic [id_width_lp-1:0] rr_ptr_reg;
  logic [id_width_lp-1:0] arb_id;
  logic [id_width_lp-1:0] grant;
  logic                   handshake;

  genvar gi;
  generate
    for (gi = 0; gi < num_src_p; gi++) begin : g_src
      logic [data_width_p-1:0] mem_reg [fifo_els_p];
      logic [ptr_w_lp-1:0]     rd_ptr_reg;
      logic [ptr_w_lp-1:0]     wr_ptr_reg;
      logic [cnt_w_lp-1:0]     count_reg;
      logic [cnt_w_lp-1:0]     count_next;
      logic                    ready_reg;
      logic                    enq;
      logic [starve_w_lp-1:0]  starve_reg;

      assign enq            = src_v_i[gi] & ready_reg;
      assign nonempty[gi]   = (count_reg != '0);
      assign head_data[gi]  = mem_reg[rd_ptr_reg];
      assign deq[gi]        = handshake & (grant == id_width_lp'(gi));
      assign src_ready_o[gi] = ready_reg;
      assign starved[gi]    = (starve_reg == starve_w_lp'(starve_limit_p));

      always_comb begin
        count_next = count_reg;
        if (enq && !deq[gi])
          count_next = count_reg + 1'b1;
        else if (!enq && deq[gi])
          count_next = count_reg - 1'b1;
      end

      // Storage has no reset so it can map onto plain RAM; pointers define validity.
      always_ff @(posedge clk_i) begin
        if (enq)
          mem_reg[wr_ptr_reg] <= src_data_i[gi*data_width_p +: data_width_p];
      end

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          count_reg  <= '0;
          ready_reg  <= 1'b0;
        end else begin
          count_reg <= count_next;
          ready_reg <= (count_next != cnt_w_lp'(fifo_els_p));
          if (enq)
            wr_ptr_reg <= (wr_ptr_reg == ptr_w_lp'(fifo_els_p - 1)) ? '0 : wr_ptr_reg + 1'b1;
          if (deq[gi])
            rd_ptr_reg <= (rd_ptr_reg == ptr_w_lp'(fifo_els_p - 1)) ? '0 : rd_ptr_reg + 1'b1;
        end
      end

      always_ff @(posedge clk_i) begin
        if (reset_i || (rr_mode_p != 0))
          starve_reg <= '0;
        else if (!nonempty[gi] || deq[gi])
          starve_reg <= '0;
        else if (starve_reg != starve_w_lp'(starve_limit_p))
          starve_reg <= starve_reg + 1'b1;
      end
    end
  endgenerate

  always_comb begin
    logic found;
    arb_id = '0;
    found  = 1'b0;
    if (rr_mode_p != 0) begin
      // Two passes: at/above the pointer first, then wrap to the lowest index.
      for (int j = 0; j < num_src_p; j++) begin
        if (!found && nonempty[j] && (j >= int'(rr_ptr_reg))) begin
          arb_id = id_width_lp'(j);
          found  = 1'b1;
        end
      end
      for (int j = 0; j < num_src_p; j++) begin
        if (!found && nonempty[j]) begin
          arb_id = id_width_lp'(j);
          found  = 1'b1;
        end
      end
    end else if (|(starved & nonempty)) begin
      for (int j = 0; j < num_src_p; j++) begin
        if (!found && starved[j] && nonempty[j]) begin
          arb_id = id_width_lp'(j);
          found  = 1'b1;
        end
      end
    end else begin
      for (int j = 0; j < num_src_p; j++) begin
        if (!found && nonempty[j]) begin
          arb_id = id_width_lp'(j);
          found  = 1'b1;
        end
      end
    end
  end

  assign grant      = lock_reg ? lock_id_reg : arb_id;
  assign resp_v_o   = |nonempty;
  assign resp_o     = head_data[grant];
  assign grant_id_o = grant;
  assign starved_o  = starved;
  assign handshake  = resp_v_o & resp_ready_i;

  // A stalled offer is pinned until it handshakes, so nothing can preempt it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_reg    <= 1'b0;
      lock_id_reg <= '0;
      rr_ptr_reg  <= '0;
    end else begin
      lock_reg    <= resp_v_o & ~resp_ready_i;
      lock_id_reg <= grant;
      if (handshake && (rr_mode_p != 0))
        rr_ptr_reg <= (grant == id_width_lp'(num_src_p - 1)) ? '0 : grant + 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_lce_resp_arbiter_n.sv
// Directed bench: a fixed-priority 2-source instance (starve limit 4) and a
// round-robin 3-source instance, checked against hand-computed expectations.
module tb_bp_lce_resp_arbiter_n;

  logic clk;
  logic reset;

  logic [15:0] f_src_data;
  logic [1:0]  f_src_v;
  logic [1:0]  f_src_ready;
  logic [7:0]  f_resp;
  logic        f_resp_v;
  logic        f_resp_ready;
  logic [0:0]  f_grant;
  logic [1:0]  f_starved;

  logic [23:0] r_src_data;
  logic [2:0]  r_src_v;
  logic [2:0]  r_src_ready;
  logic [7:0]  r_resp;
  logic        r_resp_v;
  logic        r_resp_ready;
  logic [1:0]  r_grant;
  logic [2:0]  r_starved;

  int n_checks = 0;
  int n_fail   = 0;

  bp_lce_resp_arbiter_n #(
    .num_src_p(2), .data_width_p(8), .fifo_els_p(2), .rr_mode_p(0), .starve_limit_p(4)
  ) dut_f (
    .clk_i(clk), .reset_i(reset),
    .src_data_i(f_src_data), .src_v_i(f_src_v), .src_ready_o(f_src_ready),
    .resp_o(f_resp), .resp_v_o(f_resp_v), .resp_ready_i(f_resp_ready),
    .grant_id_o(f_grant), .starved_o(f_starved)
  );

  bp_lce_resp_arbiter_n #(
    .num_src_p(3), .data_width_p(8), .fifo_els_p(2), .rr_mode_p(1), .starve_limit_p(8)
  ) dut_r (
    .clk_i(clk), .reset_i(reset),
    .src_data_i(r_src_data), .src_v_i(r_src_v), .src_ready_o(r_src_ready),
    .resp_o(r_resp), .resp_v_o(r_resp_v), .resp_ready_i(r_resp_ready),
    .grant_id_o(r_grant), .starved_o(r_starved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", tag, got, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    f_src_data   = '0;
    f_src_v      = '0;
    f_resp_ready = 1'b0;
    r_src_data   = '0;
    r_src_v      = '0;
    r_resp_ready = 1'b0;
    repeat (2) tick();

    check("rst_ready_f",   f_src_ready, 2'b00);
    check("rst_v_f",       f_resp_v,    1'b0);
    check("rst_grant_f",   f_grant,     1'b0);
    check("rst_starved_f", f_starved,   2'b00);
    check("rst_ready_r",   r_src_ready, 3'b000);

    reset = 1'b0;
    tick();
    check("rel_ready_f", f_src_ready, 2'b11);
    check("rel_v_f",     f_resp_v,    1'b0);
    check("rel_ready_r", r_src_ready, 3'b111);

    // 1: simultaneous enqueue, index 0 wins first
    f_resp_ready = 1'b1;
    f_src_data   = {8'h0B, 8'h0A};
    f_src_v      = 2'b11;
    tick();
    f_src_v = '0;
    check("t1_v",       f_resp_v, 1'b1);
    check("t1_data0",   f_resp,   8'h0A);
    check("t1_grant0",  f_grant,  1'b0);
    tick();
    check("t1_data1",   f_resp,   8'h0B);
    check("t1_grant1",  f_grant,  1'b1);
    tick();
    check("t1_empty",   f_resp_v, 1'b0);

    // 2: backpressure holds grant 1 while src0 arrives
    f_resp_ready     = 1'b0;
    f_src_data[15:8] = 8'h0B;
    f_src_v          = 2'b10;
    tick();
    f_src_v = '0;
    check("t2_hold_data",  f_resp,  8'h0B);
    check("t2_hold_grant", f_grant, 1'b1);
    f_src_data[7:0] = 8'h0A;
    f_src_v         = 2'b01;
    tick();
    f_src_v = '0;
    check("t2_lock_data",  f_resp,  8'h0B);
    check("t2_lock_grant", f_grant, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_stall_data",  f_resp,  8'h0B);
      check("t2_stall_grant", f_grant, 1'b1);
    end
    f_resp_ready = 1'b1;
    tick();
    check("t2_next_data",  f_resp,   8'h0A);
    check("t2_next_grant", f_grant,  1'b0);
    tick();
    check("t2_empty",      f_resp_v, 1'b0);

    // 3: src0 streams, src1 waits until promoted
    f_resp_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      f_src_v    = (k == 1) ? 2'b11 : 2'b01;
      f_src_data = {8'h5B, 8'(k)};
      tick();
      if (k <= 4) begin
        check("t3_stream_starved", f_starved, 2'b00);
        check("t3_stream_grant",   f_grant,   1'b0);
        check("t3_stream_data",    f_resp,    32'(k));
      end else if (k == 5) begin
        check("t3_promoted",       f_starved, 2'b10);
        check("t3_promoted_grant", f_grant,   1'b1);
        check("t3_promoted_data",  f_resp,    8'h5B);
      end else begin
        check("t3_cleared",        f_starved, 2'b00);
        check("t3_after_grant",    f_grant,   1'b0);
        check("t3_after_data",     f_resp,    8'h05);
      end
    end
    f_src_v = '0;
    for (int i = 0; i < 8 && f_resp_v; i++) tick();
    check("t3_drain", f_resp_v, 1'b0);

    // 4: round-robin rotation over three always-valid sources
    r_resp_ready = 1'b1;
    r_src_data   = {8'h30, 8'h20, 8'h10};
    r_src_v      = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t4_rr_grant", r_grant, 32'(i % 3));
      check("t4_rr_data",  r_resp,  32'((i % 3 + 1) * 16));
      check("t4_rr_starved", r_starved, 3'b000);
    end
    r_src_v = '0;
    for (int i = 0; i < 10 && r_resp_v; i++) tick();
    check("t4_drain", r_resp_v, 1'b0);

    // 5: full FIFO deasserts ready and preserves order
    f_resp_ready    = 1'b0;
    f_src_data[7:0] = 8'h01;
    f_src_v         = 2'b01;
    tick();
    check("t5_ready_after1", f_src_ready[0], 1'b1);
    f_src_data[7:0] = 8'h02;
    tick();
    check("t5_full_ready", f_src_ready[0], 1'b0);
    f_src_data[7:0] = 8'h03;
    tick();
    check("t5_held_ready", f_src_ready[0], 1'b0);
    check("t5_head1",      f_resp,         8'h01);
    f_resp_ready = 1'b1;
    tick();
    f_resp_ready = 1'b0;
    check("t5_ready_back", f_src_ready[0], 1'b1);
    check("t5_head2",      f_resp,         8'h02);
    tick();
    f_src_v = '0;
    check("t5_full_again", f_src_ready[0], 1'b0);
    check("t5_head2_hold", f_resp,         8'h02);
    f_resp_ready = 1'b1;
    tick();
    check("t5_head3", f_resp,   8'h03);
    tick();
    check("t5_empty", f_resp_v, 1'b0);

    // 6: reset with two messages queued and both sources promoted
    f_resp_ready = 1'b0;
    f_src_data   = {8'h88, 8'h77};
    f_src_v      = 2'b11;
    tick();
    f_src_v = '0;
    repeat (4) tick();
    check("t6_pre_starved", f_starved, 2'b11);
    check("t6_pre_data",    f_resp,    8'h77);
    reset = 1'b1;
    tick();
    check("t6_rst_v",       f_resp_v,    1'b0);
    check("t6_rst_starved", f_starved,   2'b00);
    check("t6_rst_grant",   f_grant,     1'b0);
    check("t6_rst_ready",   f_src_ready, 2'b00);
    reset        = 1'b0;
    f_resp_ready = 1'b1;
    tick();
    check("t6_rel_ready", f_src_ready, 2'b11);
    check("t6_rel_v",     f_resp_v,    1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_stale", f_resp_v, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_lce_resp_arbiter_n.md
Name: bp_lce_resp_arbiter_n

Overview:
- Generalised N-source arbiter for the LCE-to-CCE response channel.
- Replaces the fixed two-way combinational mux between the request engine and the command engine with a buffered arbiter.
  - Each source gets its own FIFO.
  - Priority is selectable: fixed or round-robin.
  - In fixed mode, a starvation promotion counter guarantees forward progress.
- Sits inside the LCE top, between the LCE sub-engines and the lce_resp network port.

Parameters:
- num_src_p, 2: number of response sources (>=1); index 0 is highest fixed priority.
- data_width_p, 64: width of one response message.
- fifo_els_p, 2: per-source FIFO depth (>=1).
- rr_mode_p, 0: 0 = fixed priority with starvation promotion; 1 = round-robin.
- starve_limit_p, 8: wait cycles before a source is promoted (fixed mode only, >=1).

Ports:
- clk_i, input, 1: clock.
- reset_i, input, 1: reset; synchronous, active-high.
- src_data_i, input, num_src_p*data_width_p: per-source messages; source i occupies bits [i*data_width_p +: data_width_p].
- src_v_i, input, num_src_p: per-source valid.
- src_ready_o, output, num_src_p: per-source ready. Registered, equal to FIFO not full.
- resp_o, output, data_width_p: granted message.
- resp_v_o, output, 1: resp_o valid.
- resp_ready_i, input, 1: downstream ready.
- grant_id_o, output, clog2(num_src_p) (min 1): source index of resp_o. Valid when resp_v_o is high.
- starved_o, output, num_src_p: source i is currently promoted (status).

Behaviour:
- Reset (synchronous, applied at clk_i edge while reset_i is high):
  - All FIFOs emptied, contents discarded, including in-flight messages.
  - RR pointer = 0; all starve counters = 0; grant lock cleared.
  - resp_v_o = 0, grant_id_o = 0, starved_o = 0.
  - src_ready_o = 0 while reset_i is high; all 1 on the first cycle after deassertion.
- Enqueue:
  - Source i enqueues when src_v_i[i] & src_ready_o[i].
  - src_ready_o[i] depends only on registered FIFO occupancy, never on resp_ready_i.
- Latency:
  - No bypass: a message enqueued in cycle t is earliest visible on resp_o in cycle t+1.
  - An enqueue into an empty FIFO and a dequeue in the same cycle cannot collide.
- Output valid: resp_v_o = any FIFO non-empty.
- Dequeue: the granted FIFO pops on resp_v_o & resp_ready_i.
- Grant lock (no retract):
  - If resp_v_o & ~resp_ready_i, the next cycle keeps the same grant_id_o and resp_o.
  - Newly arriving higher-priority messages do not preempt.
  - The lock clears on handshake.
- Fixed mode (rr_mode_p = 0):
  - If any starved_o bit is set, grant the lowest-index starved source with a non-empty FIFO.
  - Otherwise grant the lowest-index non-empty source.
- Starve counter, per source:
  - Increments each cycle its FIFO is non-empty and it is not dequeued.
  - Saturates at starve_limit_p; starved_o[i] = (count == starve_limit_p).
  - Clears to 0 on dequeue of that source, or when its FIFO is empty.
- Round-robin mode (rr_mode_p = 1):
  - Grant the first non-empty source searching from the RR pointer upward, wrapping modulo num_src_p.
  - On handshake, pointer <= (grant + 1) mod num_src_p.
  - Starve counters are held at 0 and starved_o = 0.
- FIFO boundaries:
  - Full: src_ready_o low; src_v_i is ignored.
  - Same-cycle enqueue and dequeue on a non-full, non-empty FIFO keeps the count unchanged.
  - Read/write pointers wrap modulo fifo_els_p.
- num_src_p = 1: pure FIFO; grant_id_o = 0.
- Width rules: starve counter width is clog2(starve_limit_p+1); RR pointer width equals grant_id_o width.

Test Plan:
1. Reset release → src_ready_o = 2'b11, resp_v_o = 0. Enqueue src0 = 0xA and src1 = 0xB in the same cycle, with resp_ready_i held 1 → next cycle 0xA with grant 0, then 0xB with grant 1 (fixed mode).
2. Backpressure: resp_ready_i = 0 for 5 cycles with 0xB pending. Enqueue 0xA on src0 during the stall → resp_o stays 0xB with grant 1 until resp_ready_i = 1; 0xA follows.
3. Starvation, num_src_p = 2, starve_limit_p = 4: src0 streams continuously, src1 holds one message → starved_o[1] rises after 4 wait cycles, src1 is granted the next handshake, then starved_o[1] = 0.
4. Round-robin, num_src_p = 3, all sources continuously valid with tags 0x10/0x20/0x30 → grant order 0, 1, 2, 0, 1, 2.
5. Full: fifo_els_p = 2, resp_ready_i = 0, src0 drives 3 messages → src_ready_o[0] = 0 after 2 accepts; the third is held. After one dequeue, ready returns and the order 1, 2, 3 is preserved.
6. Reset mid-operation with 2 messages queued → next cycle resp_v_o = 0, starved_o = 0, grant_id_o = 0; no old data appears afterwards.
